// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants for the fetch path
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_register.sv
// pc_register: fetch PC with redirect-over-stall next-PC selection
module pc_register import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Stall,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCF
);
  always_ff @(posedge CLK)
    if (RESET) PCF <= RESET_PC;
    else PCF <= PCSrcE ? PCTargetE : (Stall ? PCF : PCF + PC_INC);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage and F/D register with a one-entry skid buffer that
// keeps InstrD stable while the synchronous memory re-reads PCF under stall
module fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Stall,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] IMemAddress,
  input  logic [XLEN-1:0] IMemReadData,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  logic [XLEN-1:0] PCF, HoldInstr;
  logic vD, HoldV;
  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .PCF(PCF)
  );
  always_ff @(posedge CLK)
    if (RESET) begin
      PCD <= '0;
      vD <= 1'b0;
      HoldV <= 1'b0;
      HoldInstr <= NOP_INSTR;
    end else begin
      if (!Stall) PCD <= PCF;
      if (FlushD) vD <= 1'b0;
      else if (!Stall) vD <= 1'b1;
      // capture only on the first stall edge; later edges see the re-read of PCF
      if (Stall && !FlushD) begin
        if (!HoldV) begin
          HoldInstr <= IMemReadData;
          HoldV <= 1'b1;
        end
      end else HoldV <= 1'b0;
    end
  always_comb begin
    IMemAddress = PCF >> 2;
    InstrD = !vD ? NOP_INSTR : (HoldV ? HoldInstr : IMemReadData);
    ValidD = vD;
    PCPlus4D = PCD + PC_INC;
  end
endmodule
